// File: rtl/wb_pwm_multi_pkg.sv
// Shared constants for the Wishbone multi-channel PWM generator.
// Holds the register word map, the decoded address width and parameter limits.
package wb_pwm_multi_pkg;

    // Width of the decoded word index taken from wb_adr_i[6:2]
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_CTRL      = 5'd0;
    localparam logic [ADDR_W-1:0] REG_PRESCALE  = 5'd1;
    localparam logic [ADDR_W-1:0] REG_PERIOD    = 5'd2;
    localparam logic [ADDR_W-1:0] REG_POLARITY  = 5'd3;
    localparam logic [ADDR_W-1:0] REG_COUNT     = 5'd4;
    localparam logic [ADDR_W-1:0] REG_DUTY_BASE = 5'd8;

    localparam int unsigned MAX_CHANNELS = 16;
    localparam int unsigned MAX_RES      = 16;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM output channel.
// Holds the duty shadow/active pair, compares the shared counter against the
// active duty, applies polarity and registers the result.
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   cnt           shared period counter
//   boundary      1 on the edge that ends a period (shadow commit)
//   ena           global enable; while 0 the active duty tracks the shadow
//   wr, wr_data   duty shadow write strobe and data
//   polarity      1 inverts the output (inactive level = polarity)
//   duty_shadow   shadow value for bus readback
//   pwm           registered PWM output
module pwm_channel_cmp
    import wb_pwm_multi_pkg::*;
#(
    parameter int unsigned RES = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [RES-1:0] cnt,
    input  logic           boundary,
    input  logic           ena,
    input  logic           wr,
    input  logic [RES-1:0] wr_data,
    input  logic           polarity,
    output logic [RES-1:0] duty_shadow,
    output logic           pwm
);

    logic [RES-1:0] duty_active;
    logic           raw;

    assign raw = (cnt < duty_active);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_shadow <= '0;
            duty_active <= '0;
            pwm         <= 1'b0;
        end else begin
            if (wr) begin
                duty_shadow <= wr_data;
            end
            // Old shadow is committed even if a write lands on the same edge
            if (!ena || boundary) begin
                duty_active <= duty_shadow;
            end
            pwm <= ena ? (raw ^ polarity) : polarity;
        end
    end

endmodule

// File: rtl/wb_pwm_multi.sv
// Wishbone-slave PWM generator with a shared prescaler and period counter and
// CHANNELS independent duty/polarity channels. PERIOD and DUTY are shadowed
// and only become active at a period boundary (or continuously while disabled).
// Ports:
//   clk, rst            clock and asynchronous active-low reset
//   wb_stb_i, wb_cyc_i  Wishbone strobe / cycle
//   wb_we_i             1 = write
//   wb_adr_i            byte address, word index in [6:2]
//   wb_sel_i            ignored, all accesses are full-word
//   wb_dat_i            write data
//   wb_dat_o            registered read data
//   wb_ack_o            transfer acknowledge
//   pwm_out             registered PWM outputs
module wb_pwm_multi
    import wb_pwm_multi_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned RES        = 8,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    input  logic                wb_we_i,
    input  logic [31:0]         wb_adr_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [31:0]         wb_dat_i,
    output logic [31:0]         wb_dat_o,
    output logic                wb_ack_o,
    output logic [CHANNELS-1:0] pwm_out
);

    localparam logic [ADDR_W-1:0] NUM_CH = ADDR_W'(CHANNELS);

    logic                  strobe;
    logic                  ack_q;
    logic                  access;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_W-1:0]     word;
    logic [ADDR_W-1:0]     duty_idx;
    logic                  is_duty;

    logic                  ena_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] pre_cnt_q;
    logic [RES-1:0]        period_sh_q;
    logic [RES-1:0]        period_act_q;
    logic [RES-1:0]        cnt_q;
    logic [CHANNELS-1:0]   polarity_q;
    logic                  tick;
    logic                  boundary;

    logic [RES-1:0]        duty_sh [CHANNELS];
    logic [31:0]           rdata;
    logic                  unused_bits;

    // Bus handshake: a new access is taken only while ack is low, so a held
    // strobe is acknowledged every second cycle.
    assign strobe   = wb_stb_i & wb_cyc_i;
    assign access   = strobe & ~ack_q;
    assign wr_en    = access & wb_we_i;
    assign rd_en    = access & ~wb_we_i;
    assign wb_ack_o = strobe & ack_q;

    assign word     = wb_adr_i[6:2];
    assign duty_idx = word - REG_DUTY_BASE;
    assign is_duty  = (word >= REG_DUTY_BASE) && (duty_idx < NUM_CH);

    assign tick     = ena_q && (pre_cnt_q == prescale_q);
    assign boundary = tick && (cnt_q == period_act_q);

    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:7], wb_adr_i[1:0], wb_dat_i};

    always_comb begin
        rdata = '0;
        case (word)
            REG_CTRL:     rdata = {31'd0, ena_q};
            REG_PRESCALE: rdata = 32'(prescale_q);
            REG_PERIOD:   rdata = 32'(period_sh_q);
            REG_POLARITY: rdata = 32'(polarity_q);
            REG_COUNT:    rdata = 32'(cnt_q);
            default: begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    if (is_duty && (duty_idx == ADDR_W'(i))) begin
                        rdata = 32'(duty_sh[i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q        <= 1'b0;
            wb_dat_o     <= '0;
            ena_q        <= 1'b0;
            prescale_q   <= '0;
            period_sh_q  <= '1;
            period_act_q <= '1;
            polarity_q   <= '0;
            pre_cnt_q    <= '0;
            cnt_q        <= '0;
        end else begin
            ack_q <= access;
            if (rd_en) begin
                wb_dat_o <= rdata;
            end
            if (wr_en) begin
                case (word)
                    REG_CTRL:     ena_q       <= wb_dat_i[0];
                    REG_PRESCALE: prescale_q  <= wb_dat_i[PRESCALE_W-1:0];
                    REG_PERIOD:   period_sh_q <= wb_dat_i[RES-1:0];
                    REG_POLARITY: polarity_q  <= wb_dat_i[CHANNELS-1:0];
                    default:      ;
                endcase
            end

            if (!ena_q) begin
                pre_cnt_q <= '0;
                cnt_q     <= '0;
            end else if (tick) begin
                pre_cnt_q <= '0;
                cnt_q     <= boundary ? '0 : cnt_q + RES'(1);
            end else begin
                pre_cnt_q <= pre_cnt_q + PRESCALE_W'(1);
            end

            if (!ena_q || boundary) begin
                period_act_q <= period_sh_q;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel_cmp #(
            .RES(RES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .cnt        (cnt_q),
            .boundary   (boundary),
            .ena        (ena_q),
            .wr         (wr_en && is_duty && (duty_idx == ADDR_W'(i))),
            .wr_data    (wb_dat_i[RES-1:0]),
            .polarity   (polarity_q[i]),
            .duty_shadow(duty_sh[i]),
            .pwm        (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_wb_pwm_multi.sv
// Self-checking bench for wb_pwm_multi (CHANNELS=4, RES=8, PRESCALE_W=16).
// Expected PWM samples and read data are pushed to queues from a closed-form
// model of counter position (edges since enable) and popped as the DUT responds.
module tb_wb_pwm_multi;

    localparam int CH     = 4;
    localparam int NEVER  = 1 << 30;
    localparam int W_CTRL = 0;
    localparam int W_PRE  = 1;
    localparam int W_PER  = 2;
    localparam int W_POL  = 3;
    localparam int W_CNT  = 4;
    localparam int W_DUTY = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_stb_i;
    logic          wb_cyc_i;
    logic          wb_we_i;
    logic [31:0]   wb_adr_i;
    logic [3:0]    wb_sel_i;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic [CH-1:0] pwm_out;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    // Model state: ec = edge where CTRL=1 committed; k below = edges since ec
    int            ec;
    int            pres;
    int            per0;
    int            per1;
    int            per_b;
    int            duty_b;
    int            pol_k;
    int            duty0 [CH];
    int            duty1 [CH];
    logic [CH-1:0] pol0;
    logic [CH-1:0] pol1;

    logic [31:0]   rd_q [$];
    logic [CH-1:0] pwm_q [$];

    wb_pwm_multi #(
        .CHANNELS  (CH),
        .RES       (8),
        .PRESCALE_W(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i),
        .wb_we_i (wb_we_i),
        .wb_adr_i(wb_adr_i),
        .wb_sel_i(wb_sel_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d",
                 tests_run, tests_failed);
        $fatal(1);
    end

    // Counter value after edge ec+k
    function automatic int cnt_at(input int k);
        if (k < per_b) return (k / (pres + 1)) % (per0 + 1);
        return ((k - per_b) / (pres + 1)) % (per1 + 1);
    endfunction

    // pwm_out after edge ec+k (k >= 1): uses counter and duty from the edge before
    function automatic logic [CH-1:0] pwm_at(input int k);
        logic [CH-1:0] r;
        int c;
        c = cnt_at(k - 1);
        for (int i = 0; i < CH; i++) begin
            int d;
            d = (k - 1 >= duty_b) ? duty1[i] : duty0[i];
            r[i] = (c < d) ^ ((k > pol_k) ? pol1[i] : pol0[i]);
        end
        return r;
    endfunction

    task automatic model_reset(input int p, input int per, input int d0, input int d1,
                               input int d2, input int d3, input logic [CH-1:0] pol);
        pres   = p;
        per0   = per;
        per1   = per;
        per_b  = NEVER;
        duty_b = NEVER;
        pol_k  = NEVER;
        duty0[0] = d0; duty0[1] = d1; duty0[2] = d2; duty0[3] = d3;
        duty1 = duty0;
        pol0  = pol;
        pol1  = pol;
    endtask

    task automatic bus_write(input int word, input logic [31:0] data, output int edge_k);
        int n;
        n = 0;
        wb_adr_i = 32'(word) << 2;
        wb_dat_i = data;
        wb_we_i  = 1'b1;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack_o && n < 8);
        tests_run++;
        if (wb_ack_o !== 1'b1 || n != 1) begin
            tests_failed++;
            $display("FAIL write_ack word=%0d: ack=%b after %0d cycles, want ack=1 after 1",
                     word, wb_ack_o, n);
        end
        edge_k   = cycle;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge clk); #1;
    endtask

    // Expected value must already be queued in rd_q
    task automatic bus_read(input int word, input string name);
        logic [31:0] want;
        int n;
        n = 0;
        wb_adr_i = 32'(word) << 2;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack_o && n < 8);
        want = rd_q.pop_front();
        tests_run++;
        if (wb_ack_o !== 1'b1 || n != 1 || wb_dat_o !== want) begin
            tests_failed++;
            $display("FAIL %s: ack=%b cycles=%0d data=0x%08h, want ack=1 cycles=1 data=0x%08h",
                     name, wb_ack_o, n, wb_dat_o, want);
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic read_count(input string name);
        rd_q.push_back(32'(cnt_at(cycle - ec)));
        bus_read(W_CNT, name);
    endtask

    task automatic check_pwm(input int n, input string name);
        for (int j = 1; j <= n; j++) pwm_q.push_back(pwm_at(cycle - ec + j));
        for (int j = 1; j <= n; j++) begin
            logic [CH-1:0] want;
            @(posedge clk); #1;
            want = pwm_q.pop_front();
            tests_run++;
            if (pwm_out !== want) begin
                tests_failed++;
                $display("FAIL %s k=%0d: pwm_out=%b want=%b", name, cycle - ec, pwm_out, want);
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_sel_i = 4'hf;
        wb_dat_i = '0;
        #1;
        tests_run++;
        if (pwm_out !== '0 || wb_ack_o !== 1'b0 || wb_dat_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: pwm=%b ack=%b dat=0x%08h, want 0 0 0",
                     pwm_out, wb_ack_o, wb_dat_o);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rd_q.push_back(32'h0);  bus_read(W_CTRL, "reset_ctrl");
        rd_q.push_back(32'h0);  bus_read(W_PRE, "reset_prescale");
        rd_q.push_back(32'hff); bus_read(W_PER, "reset_period");
        rd_q.push_back(32'h0);  bus_read(W_POL, "reset_polarity");
        rd_q.push_back(32'h0);  bus_read(W_CNT, "reset_count");
        rd_q.push_back(32'h0);  bus_read(W_DUTY, "reset_duty0");
    endtask

    // PERIOD=9, PRESCALE=0, DUTY={3,0,10,9}: ch1 never active, ch2 always,
    // ch3 active for all counts except the last
    task automatic test_basic_waveform();
        int k;
        bus_write(W_PER, 32'd9, k);
        bus_write(W_PRE, 32'd0, k);
        bus_write(W_DUTY + 0, 32'd3, k);
        bus_write(W_DUTY + 1, 32'd0, k);
        bus_write(W_DUTY + 2, 32'd10, k);
        bus_write(W_DUTY + 3, 32'd9, k);
        model_reset(0, 9, 3, 0, 10, 9, '0);
        bus_write(W_CTRL, 32'd1, ec);
        check_pwm(30, "basic_pwm");
        for (int i = 0; i < 5; i++) read_count("basic_count");
    endtask

    task automatic test_shadow_commit();
        int kw;
        for (int n = 0; n < 40 && cnt_at(cycle - ec) != 4; n++) begin
            @(posedge clk); #1;
        end
        bus_write(W_DUTY + 0, 32'd7, kw);
        duty1    = duty0;
        duty1[0] = 7;
        duty_b   = ((kw - ec) / 10 + 1) * 10;
        check_pwm(40, "shadow_pwm");
    endtask

    task automatic test_polarity();
        int kp;
        bus_write(W_POL, 32'h1, kp);
        pol1  = 4'b0001;
        pol_k = kp - ec;
        check_pwm(20, "polarity_pwm");
    endtask

    task automatic test_bus();
        int k;
        logic exp_ack;
        rd_q.push_back(32'h7); bus_read(W_DUTY, "read_duty0");
        tests_run++;
        if (wb_ack_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_one_cycle: ack=%b, want 0", wb_ack_o);
        end
        rd_q.push_back(32'h9); bus_read(W_PER, "read_period");
        rd_q.push_back(32'h1); bus_read(W_POL, "read_polarity");
        rd_q.push_back(32'h1); bus_read(W_CTRL, "read_ctrl");
        rd_q.push_back(32'h0); bus_read(30, "read_unmapped");
        bus_write(W_CNT, 32'h55, k);
        read_count("count_after_write");
        // Held strobe: ack pattern 1,0,1,0,...
        wb_adr_i = 32'(W_DUTY) << 2;
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            exp_ack = (i % 2 == 0);
            tests_run++;
            if (wb_ack_o !== exp_ack) begin
                tests_failed++;
                $display("FAIL held_strobe cycle %0d: ack=%b want=%b", i, wb_ack_o, exp_ack);
            end
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // stb without cyc must never be acknowledged
        wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (wb_ack_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL no_cyc_ack cycle %0d: ack=%b want=0", i, wb_ack_o);
            end
        end
        wb_stb_i = 1'b0;
        @(posedge clk); #1;
    endtask

    // PRESCALE=3, PERIOD=9: 40-clock period; PERIOD=4 applies after it ends
    task automatic test_prescaler();
        int k;
        int kw;
        bus_write(W_CTRL, 32'd0, k);
        bus_write(W_POL, 32'd0, k);
        bus_write(W_PRE, 32'd3, k);
        bus_write(W_PER, 32'd9, k);
        bus_write(W_DUTY + 0, 32'd3, k);
        model_reset(3, 9, 3, 0, 10, 9, '0);
        bus_write(W_CTRL, 32'd1, ec);
        check_pwm(8, "prescale_pwm");
        bus_write(W_PER, 32'd4, kw);
        per1  = 4;
        per_b = ((kw - ec) / 40 + 1) * 40;
        check_pwm(100, "period_change_pwm");
        read_count("prescale_count_a");
        read_count("prescale_count_b");
    endtask

    task automatic test_reset_midrun();
        rd_q.push_back(32'h4); bus_read(W_PER, "read_period_new");
        for (int n = 0; n < 40 && cnt_at(cycle - ec) != 3; n++) begin
            @(posedge clk); #1;
        end
        tests_run++;
        if (pwm_out !== pwm_at(cycle - ec)) begin
            tests_failed++;
            $display("FAIL pre_reset_pwm: pwm=%b want=%b", pwm_out, pwm_at(cycle - ec));
        end
        #3 rst = 1'b0;
        #1;
        tests_run++;
        if (pwm_out !== '0 || wb_dat_o !== '0 || wb_ack_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: pwm=%b dat=0x%08h ack=%b, want 0 0 0",
                     pwm_out, wb_dat_o, wb_ack_o);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rd_q.push_back(32'hff); bus_read(W_PER, "midrun_period");
        rd_q.push_back(32'h0);  bus_read(W_CTRL, "midrun_ctrl");
        rd_q.push_back(32'h0);  bus_read(W_PRE, "midrun_prescale");
        rd_q.push_back(32'h0);  bus_read(W_POL, "midrun_polarity");
        rd_q.push_back(32'h0);  bus_read(W_DUTY + 0, "midrun_duty0");
        rd_q.push_back(32'h0);  bus_read(W_DUTY + 2, "midrun_duty2");
        rd_q.push_back(32'h0);  bus_read(W_CNT, "midrun_count");
    endtask

    task automatic test_disable();
        int k;
        int kd;
        bus_write(W_PER, 32'd9, k);
        bus_write(W_DUTY + 0, 32'd3, k);
        bus_write(W_POL, 32'h3, k);
        model_reset(0, 9, 3, 0, 0, 0, 4'b0011);
        bus_write(W_CTRL, 32'd1, ec);
        check_pwm(12, "inverted_pwm");
        bus_write(W_CTRL, 32'd0, kd);
        tests_run++;
        if (pwm_out !== 4'b0011) begin
            tests_failed++;
            $display("FAIL disable_pwm: pwm=%b want=0011", pwm_out);
        end
        rd_q.push_back(32'h0); bus_read(W_CNT, "disable_count");
    endtask

    initial begin
        test_reset();
        test_basic_waveform();
        test_shadow_commit();
        test_polarity();
        test_bus();
        test_prescaler();
        test_reset_midrun();
        test_disable();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
